playfield_engine: RTL and testbench

Parametrised successor to the fixed 10x23 board store inside the game core. It owns the settled-block playfield, writes a locked tetromino's four cells through a valid/ready handshake, and clears every completed row with a multi-cycle scan/shift sequencer. It also accumulates line and score totals. It sits between the piece-motion datapath (which supplies the four cell coordinates and uses the collision probe) and the VGA renderer (which reads `flat_board`).

---
 rtl/playfield_engine.sv | 188 ++++++++++++++++++
 tb/tb_playfield_engine.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/playfield_engine.sv
// Settled-block playfield store with a valid/ready lock port, a scan/shift
// row-clear sequencer, line/score totals and a combinational collision probe.
module playfield_engine #(
    parameter int COLS     = 10,
    parameter int ROWS     = 23,
    parameter int VIS_ROWS = 20,
    parameter int XW       = 4,
    parameter int YW       = 5,
    parameter int SCORE_W  = 16
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 clear_board,
    input  logic                 lock_valid,
    output logic                 lock_ready,
    input  logic [4*XW-1:0]      lock_x,
    input  logic [4*YW-1:0]      lock_y,
    input  logic [4*XW-1:0]      probe_x,
    input  logic [4*YW-1:0]      probe_y,
    output logic                 probe_hit,
    output logic [COLS*ROWS-1:0] flat_board,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           lines_last,
    output logic [15:0]          lines_total,
    output logic [SCORE_W-1:0]   score,
    output logic                 overflow
);

    typedef enum logic [1:0] {StIdle, StScan, StShift, StReport} state_e;

    state_e              state_q, state_d;
    logic [COLS-1:0]     board_q [ROWS];
    logic [COLS-1:0]     board_d [ROWS];
    logic [2:0]          cnt_q, cnt_d;
    logic [YW-1:0]       row_q, row_d;
    logic [2:0]          lines_last_q, lines_last_d;
    logic [15:0]         total_q, total_d;
    logic [SCORE_W-1:0]  score_q, score_d;

    logic                scan_found;
    logic [YW-1:0]       scan_row;
    logic [3:0]          points;
    logic [16:0]         total_sum;
    logic [SCORE_W:0]    score_sum;

    // Status outputs decoded straight from the state register.
    always_comb begin
        lock_ready  = (state_q == StIdle) && !clear_board;
        busy        = (state_q != StIdle);
        done        = (state_q == StReport);
        lines_last  = lines_last_q;
        lines_total = total_q;
        score       = score_q;
    end

    // Flatten the row array for the renderer.
    always_comb begin
        flat_board = '0;
        for (int r = 0; r < ROWS; r++) begin
            flat_board[r*COLS +: COLS] = board_q[r];
        end
    end

    // Any filled cell in the hidden spawn rows means the stack has topped out.
    always_comb begin
        overflow = 1'b0;
        for (int r = VIS_ROWS; r < ROWS; r++) begin
            overflow = overflow | (|board_q[r]);
        end
    end

    // Collision probe: off-board cells count as hits.
    always_comb begin
        probe_hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (int'(probe_x[i*XW +: XW]) >= COLS || int'(probe_y[i*YW +: YW]) >= ROWS) begin
                probe_hit = 1'b1;
            end else if (board_q[probe_y[i*YW +: YW]][probe_x[i*XW +: XW]]) begin
                probe_hit = 1'b1;
            end
        end
    end

    // Lowest completely filled visible row; descending loop lets the lowest win.
    always_comb begin
        scan_found = 1'b0;
        scan_row   = '0;
        for (int r = VIS_ROWS - 1; r >= 0; r--) begin
            if (&board_q[r]) begin
                scan_found = 1'b1;
                scan_row   = YW'(r);
            end
        end
    end

    // Points per lock and saturating accumulator sums.
    always_comb begin
        unique case (cnt_q)
            3'd0:    points = 4'd0;
            3'd1:    points = 4'd1;
            3'd2:    points = 4'd3;
            3'd3:    points = 4'd5;
            default: points = 4'd8;
        endcase
        total_sum = {1'b0, total_q} + 17'(cnt_q);
        score_sum = {1'b0, score_q} + (SCORE_W+1)'(points);
    end

    // Sequencer next-state and board update.
    always_comb begin
        state_d      = state_q;
        board_d      = board_q;
        cnt_d        = cnt_q;
        row_d        = row_q;
        lines_last_d = lines_last_q;
        total_d      = total_q;
        score_d      = score_q;
        unique case (state_q)
            StIdle: begin
                if (clear_board) begin
                    for (int r = 0; r < ROWS; r++) begin
                        board_d[r] = '0;
                    end
                    lines_last_d = '0;
                    total_d      = '0;
                    score_d      = '0;
                end else if (lock_valid) begin
                    // Out-of-bounds cells are silently dropped.
                    for (int i = 0; i < 4; i++) begin
                        if (int'(lock_x[i*XW +: XW]) < COLS && int'(lock_y[i*YW +: YW]) < ROWS) begin
                            board_d[lock_y[i*YW +: YW]][lock_x[i*XW +: XW]] = 1'b1;
                        end
                    end
                    cnt_d   = '0;
                    state_d = StScan;
                end
            end
            StScan: begin
                if (scan_found) begin
                    row_d   = scan_row;
                    cnt_d   = (cnt_q == 3'd7) ? 3'd7 : cnt_q + 3'd1;
                    state_d = StShift;
                end else begin
                    state_d = StReport;
                end
            end
            StShift: begin
                for (int k = 0; k < ROWS - 1; k++) begin
                    if (k >= int'(row_q)) begin
                        board_d[k] = board_q[k+1];
                    end
                end
                board_d[ROWS-1] = '0;
                state_d         = StScan;
            end
            StReport: begin
                lines_last_d = cnt_q;
                total_d      = total_sum[16] ? 16'hFFFF : total_sum[15:0];
                score_d      = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and board registers; reset aborts any sequence in progress.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StIdle;
            board_q      <= '{default: '0};
            cnt_q        <= '0;
            row_q        <= '0;
            lines_last_q <= '0;
            total_q      <= '0;
            score_q      <= '0;
        end else begin
            state_q      <= state_d;
            board_q      <= board_d;
            cnt_q        <= cnt_d;
            row_q        <= row_d;
            lines_last_q <= lines_last_d;
            total_q      <= total_d;
            score_q      <= score_d;
        end
    end

endmodule

// File: tb/tb_playfield_engine.sv
// Directed bench for playfield_engine. A second instance with a 4-bit score
// shares all inputs so score saturation is reachable in a short run.
module tb_playfield_engine;

    localparam int COLS = 10;
    localparam int ROWS = 23;
    localparam int NB   = COLS * ROWS;

    logic            clock = 1'b0;
    logic            resetn = 1'b0;
    logic            clear_board = 1'b0;
    logic            lock_valid = 1'b0;
    logic [15:0]     lock_x = '0;
    logic [19:0]     lock_y = '0;
    logic [15:0]     probe_x = '0;
    logic [19:0]     probe_y = '0;
    logic            lock_ready, probe_hit, busy, done, overflow;
    logic [NB-1:0]   flat_board;
    logic [2:0]      lines_last;
    logic [15:0]     lines_total;
    logic [15:0]     score;

    logic            s_lock_ready, s_probe_hit, s_busy, s_done, s_overflow;
    logic [NB-1:0]   s_flat_board;
    logic [2:0]      s_lines_last;
    logic [15:0]     s_lines_total;
    logic [3:0]      s_score;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    playfield_engine dut (
        .clock(clock), .resetn(resetn), .clear_board(clear_board),
        .lock_valid(lock_valid), .lock_ready(lock_ready),
        .lock_x(lock_x), .lock_y(lock_y), .probe_x(probe_x), .probe_y(probe_y),
        .probe_hit(probe_hit), .flat_board(flat_board), .busy(busy), .done(done),
        .lines_last(lines_last), .lines_total(lines_total), .score(score),
        .overflow(overflow)
    );

    playfield_engine #(.SCORE_W(4)) sat_dut (
        .clock(clock), .resetn(resetn), .clear_board(clear_board),
        .lock_valid(lock_valid), .lock_ready(s_lock_ready),
        .lock_x(lock_x), .lock_y(lock_y), .probe_x(probe_x), .probe_y(probe_y),
        .probe_hit(s_probe_hit), .flat_board(s_flat_board), .busy(s_busy), .done(s_done),
        .lines_last(s_lines_last), .lines_total(s_lines_total), .score(s_score),
        .overflow(s_overflow)
    );

    function automatic logic [15:0] px4(input int a, input int b, input int c, input int d);
        return {4'(d), 4'(c), 4'(b), 4'(a)};
    endfunction

    function automatic logic [19:0] py4(input int a, input int b, input int c, input int d);
        return {5'(d), 5'(c), 5'(b), 5'(a)};
    endfunction

    // Lock a piece; report the edge (after E0) where done and lock_ready are first seen.
    task automatic do_lock(input logic [15:0] lx, input logic [19:0] ly,
                           output int done_at, output int ready_at);
        done_at  = -1;
        ready_at = -1;
        @(negedge clock);
        lock_x     = lx;
        lock_y     = ly;
        lock_valid = 1'b1;
        @(posedge clock);
        #1 lock_valid = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clock);
            #1;
            if (done && done_at < 0) done_at = n;
            if (lock_ready) begin
                ready_at = n;
                break;
            end
        end
    endtask

    task automatic do_clear();
        @(negedge clock);
        clear_board = 1'b1;
        @(posedge clock);
        #1 clear_board = 1'b0;
    endtask

    // Fill rows 0..nrows-1, columns 0..8, using padding cells at y=31.
    task automatic preload_rows(input int nrows);
        int d, r;
        int ncell;
        logic [15:0] lx;
        logic [19:0] ly;
        ncell = nrows * 9;
        for (int p = 0; p < (ncell + 3) / 4; p++) begin
            for (int i = 0; i < 4; i++) begin
                int j;
                j = p * 4 + i;
                lx[i*4 +: 4] = (j < ncell) ? 4'(j % 9) : 4'd0;
                ly[i*5 +: 5] = (j < ncell) ? 5'(j / 9) : 5'd31;
            end
            do_lock(lx, ly, d, r);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        probe_x = px4(0, 1, 2, 3);
        probe_y = py4(0, 0, 0, 0);
        #12;
        vectors++; if (flat_board !== '0) begin miscompares++;
            $display("FAIL reset_board got %h want 0", flat_board); end
        vectors++; if ({busy, done, lock_ready, overflow} !== 4'b0010) begin miscompares++;
            $display("FAIL reset_status got %b want 0010", {busy, done, lock_ready, overflow}); end
        vectors++; if ({score, lines_total, lines_last} !== 35'd0) begin miscompares++;
            $display("FAIL reset_totals got %0d/%0d/%0d want 0/0/0", score, lines_total, lines_last); end
        vectors++; if (probe_hit !== 1'b0) begin miscompares++;
            $display("FAIL reset_probe got %b want 0", probe_hit); end
        @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic test_no_clear();
        int d, r;
        logic [NB-1:0] exp;
        exp = '0;
        exp[18*COLS+4] = 1'b1; exp[18*COLS+5] = 1'b1;
        exp[19*COLS+4] = 1'b1; exp[19*COLS+5] = 1'b1;
        do_lock(px4(4, 4, 5, 5), py4(19, 18, 19, 18), d, r);
        vectors++; if (flat_board !== exp) begin miscompares++;
            $display("FAIL noclear_board got %h want %h", flat_board, exp); end
        vectors++; if (d !== 1 || r !== 2) begin miscompares++;
            $display("FAIL noclear_timing got done@%0d ready@%0d want 1/2", d, r); end
        vectors++; if (lines_last !== 3'd0 || score !== 16'd0) begin miscompares++;
            $display("FAIL noclear_totals got %0d/%0d want 0/0", lines_last, score); end
    endtask

    task automatic test_single_clear();
        int d, r;
        logic [NB-1:0] exp;
        do_clear();
        vectors++; if (flat_board !== '0) begin miscompares++;
            $display("FAIL clear_board got %h want 0", flat_board); end
        do_lock(px4(0, 1, 2, 3), py4(0, 0, 0, 0), d, r);
        do_lock(px4(4, 5, 6, 7), py4(0, 0, 0, 0), d, r);
        do_lock(px4(8, 3, 0, 0), py4(0, 1, 31, 31), d, r);
        do_lock(px4(9, 9, 9, 9), py4(0, 1, 2, 3), d, r);
        exp = '0;
        exp[0*COLS+3] = 1'b1; exp[0*COLS+9] = 1'b1;
        exp[1*COLS+9] = 1'b1; exp[2*COLS+9] = 1'b1;
        vectors++; if (flat_board !== exp) begin miscompares++;
            $display("FAIL single_board got %h want %h", flat_board, exp); end
        vectors++; if (d !== 3 || r !== 4) begin miscompares++;
            $display("FAIL single_timing got done@%0d ready@%0d want 3/4", d, r); end
        vectors++; if (lines_last !== 3'd1 || score !== 16'd1 || lines_total !== 16'd1) begin
            miscompares++;
            $display("FAIL single_totals got %0d/%0d/%0d want 1/1/1", lines_last, score, lines_total); end
    endtask

    task automatic test_probe();
        int d, r;
        logic [NB-1:0] exp;
        do_clear();
        do_lock(px4(0, 1, 2, 0), py4(0, 0, 0, 25), d, r);
        exp = '0;
        exp[0] = 1'b1; exp[1] = 1'b1; exp[2] = 1'b1;
        vectors++; if (flat_board !== exp) begin miscompares++;
            $display("FAIL probe_dropcell got %h want %h", flat_board, exp); end
        probe_x = px4(10, 5, 5, 5); probe_y = py4(5, 5, 6, 7); #1;
        vectors++; if (probe_hit !== 1'b1) begin miscompares++;
            $display("FAIL probe_x10 got %b want 1", probe_hit); end
        probe_x = px4(5, 5, 1, 5); probe_y = py4(5, 6, 0, 7); #1;
        vectors++; if (probe_hit !== 1'b1) begin miscompares++;
            $display("FAIL probe_occupied got %b want 1", probe_hit); end
        probe_x = px4(3, 4, 3, 9); probe_y = py4(0, 0, 1, 22); #1;
        vectors++; if (probe_hit !== 1'b0) begin miscompares++;
            $display("FAIL probe_free got %b want 0", probe_hit); end
        probe_x = px4(3, 4, 3, 0); probe_y = py4(0, 0, 1, 23); #1;
        vectors++; if (probe_hit !== 1'b1) begin miscompares++;
            $display("FAIL probe_y23 got %b want 1", probe_hit); end
    endtask

    task automatic test_four_clear();
        int d, r;
        do_clear();
        preload_rows(4);
        do_lock(px4(9, 9, 9, 9), py4(0, 1, 2, 3), d, r);
        vectors++; if (flat_board !== '0) begin miscompares++;
            $display("FAIL four_board got %h want 0", flat_board); end
        vectors++; if (d !== 9 || r !== 10) begin miscompares++;
            $display("FAIL four_timing got done@%0d ready@%0d want 9/10", d, r); end
        vectors++; if (lines_last !== 3'd4 || score !== 16'd8 || lines_total !== 16'd4) begin
            miscompares++;
            $display("FAIL four_totals got %0d/%0d/%0d want 4/8/4", lines_last, score, lines_total); end
    endtask

    task automatic test_overflow();
        int d, r;
        do_lock(px4(0, 1, 0, 1), py4(20, 20, 21, 21), d, r);
        vectors++; if (overflow !== 1'b1) begin miscompares++;
            $display("FAIL overflow_set got %b want 1", overflow); end
        @(negedge clock);
        clear_board = 1'b1;
        lock_valid  = 1'b1;
        lock_x = px4(0, 1, 2, 3);
        lock_y = py4(5, 5, 5, 5);
        #1;
        vectors++; if (lock_ready !== 1'b0) begin miscompares++;
            $display("FAIL clear_ready got %b want 0", lock_ready); end
        @(posedge clock);
        #1 clear_board = 1'b0; lock_valid = 1'b0;
        vectors++; if (flat_board !== '0 || overflow !== 1'b0) begin miscompares++;
            $display("FAIL clear_wins_board got %h ovf %b want 0", flat_board, overflow); end
        vectors++; if (score !== 16'd0 || busy !== 1'b0) begin miscompares++;
            $display("FAIL clear_wins_state got score %0d busy %b want 0/0", score, busy); end
    endtask

    task automatic test_saturation();
        int d, r;
        preload_rows(4);
        do_lock(px4(9, 9, 9, 9), py4(0, 1, 2, 3), d, r);
        vectors++; if (s_score !== 4'd8) begin miscompares++;
            $display("FAIL sat_first got %0d want 8", s_score); end
        preload_rows(4);
        do_lock(px4(9, 9, 9, 9), py4(0, 1, 2, 3), d, r);
        vectors++; if (score !== 16'd16 || lines_total !== 16'd8) begin miscompares++;
            $display("FAIL sat_wide got %0d/%0d want 16/8", score, lines_total); end
        vectors++; if (s_score !== 4'd15) begin miscompares++;
            $display("FAIL sat_clamp got %0d want 15", s_score); end
    endtask

    task automatic test_abort();
        int d, r;
        preload_rows(1);
        @(negedge clock);
        lock_x = px4(9, 9, 9, 9);
        lock_y = py4(0, 1, 2, 3);
        lock_valid = 1'b1;
        @(posedge clock);
        #1 lock_valid = 1'b0;
        @(posedge clock);
        #1;
        vectors++; if (busy !== 1'b1 || flat_board === '0) begin miscompares++;
            $display("FAIL abort_pre got busy %b board %h want busy 1, nonzero", busy, flat_board); end
        #2 resetn = 1'b0;
        #1;
        vectors++; if (flat_board !== '0) begin miscompares++;
            $display("FAIL abort_board got %h want 0", flat_board); end
        vectors++; if ({busy, done, lock_ready} !== 3'b001) begin miscompares++;
            $display("FAIL abort_status got %b want 001", {busy, done, lock_ready}); end
        vectors++; if (score !== 16'd0 || lines_total !== 16'd0 || lines_last !== 3'd0) begin
            miscompares++;
            $display("FAIL abort_totals got %0d/%0d/%0d want 0/0/0", score, lines_total, lines_last); end
        @(negedge clock);
        resetn = 1'b1;
    endtask

    initial begin
        test_reset();
        test_no_clear();
        test_single_clear();
        test_probe();
        test_four_clear();
        test_overflow();
        test_saturation();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
